sdram_port_arbiter: RTL and testbench

- Two-master arbiter in front of the single-port SDRAM controller.
- Masters: the CPU memory controller (single-word read/write) and the video controller (burst reads only).
- Multiplexes commands onto the controller's strobe interface and routes ready/ack back to the owning master.
- Video has fixed priority by default, because scan-out is real-time.

---
 rtl/sdram_arb_pkg.sv | 22 ++
 rtl/sdram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-master SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_CPU   = 2'd1,
    OWN_VIDEO = 2'd2
  } owner_t;

  localparam int DEFAULT_BURST_LEN = 4;
  localparam int SDRAM_DATA_W      = 16;
  localparam int SDRAM_MASK_W      = 2;

  // Encoding of the round-robin last_grant bit.
  localparam logic LAST_GRANT_CPU   = 1'b0;
  localparam logic LAST_GRANT_VIDEO = 1'b1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter.sv
// CPU/video arbiter in front of the single-port SDRAM controller; video has fixed
// priority unless SDRAM_ARB_ROUND_ROBIN_EN is defined (alternating on contention).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_LEN = DEFAULT_BURST_LEN,
  parameter int ADDR_W    = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  output logic                    sdram_rd,
  output logic                    sdram_wr,
  output logic [ADDR_W-1:0]       sdram_addr_x16,
  output logic [SDRAM_DATA_W-1:0] sdram_wdata,
  output logic [SDRAM_MASK_W-1:0] sdram_wmask,
  output logic                    sdram_burst,
  input  logic [SDRAM_DATA_W-1:0] sdram_rdata,
  input  logic                    sdram_ack,
  input  logic                    sdram_rdy,

  input  logic                    cpu_sdram_rd,
  input  logic                    cpu_sdram_wr,
  input  logic [ADDR_W-1:0]       cpu_sdram_addr_x16,
  input  logic [SDRAM_DATA_W-1:0] cpu_sdram_wdata,
  input  logic [SDRAM_MASK_W-1:0] cpu_sdram_wmask,
  output logic [SDRAM_DATA_W-1:0] cpu_sdram_rdata,
  output logic                    cpu_sdram_ack,
  output logic                    cpu_sdram_rdy,

  input  logic                    video_sdram_rd,
  input  logic [ADDR_W-1:0]       video_sdram_addr_x16,
  output logic [SDRAM_DATA_W-1:0] video_sdram_rdata,
  output logic                    video_sdram_ack,
  output logic                    video_sdram_rdy
);

  localparam int               CNT_W    = cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_ACK = CNT_W'(BURST_LEN - 1);

  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;

  logic cpu_req;
  logic grant_ok;
  logic grant_cpu;
  logic grant_video;

  assign cpu_req  = cpu_sdram_rd | cpu_sdram_wr;
  // Reset gates the grant so no strobe escapes while reset is held.
  assign grant_ok = (owner_q == OWN_IDLE) && sdram_rdy && !rst_i;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  always_comb begin
    grant_video = 1'b0;
    grant_cpu   = 1'b0;
    if (grant_ok) begin
      if (video_sdram_rd && cpu_req) begin
        grant_video = (last_grant_q == LAST_GRANT_CPU);
        grant_cpu   = (last_grant_q == LAST_GRANT_VIDEO);
      end else begin
        grant_video = video_sdram_rd;
        grant_cpu   = cpu_req;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= LAST_GRANT_CPU;
    end else if (grant_video) begin
      last_grant_q <= LAST_GRANT_VIDEO;
    end else if (grant_cpu) begin
      last_grant_q <= LAST_GRANT_CPU;
    end
  end
`else
  assign grant_video = grant_ok && video_sdram_rd;
  assign grant_cpu   = grant_ok && cpu_req && !video_sdram_rd;
`endif

  assign cpu_sdram_rdy   = grant_cpu;
  assign video_sdram_rdy = grant_video;

  // Command mux; address and data idle on the CPU inputs.
  always_comb begin
    sdram_rd       = 1'b0;
    sdram_wr       = 1'b0;
    sdram_burst    = 1'b0;
    sdram_addr_x16 = cpu_sdram_addr_x16;
    sdram_wdata    = cpu_sdram_wdata;
    sdram_wmask    = cpu_sdram_wmask;
    if (grant_video) begin
      sdram_rd       = 1'b1;
      sdram_burst    = 1'b1;
      sdram_addr_x16 = video_sdram_addr_x16;
      sdram_wdata    = '0;
      sdram_wmask    = '1;
    end else if (grant_cpu) begin
      sdram_wr = cpu_sdram_wr;
      sdram_rd = !cpu_sdram_wr;
    end
  end

  assign cpu_sdram_ack     = sdram_ack && (owner_q == OWN_CPU);
  assign video_sdram_ack   = sdram_ack && (owner_q == OWN_VIDEO);
  assign cpu_sdram_rdata   = sdram_rdata;
  assign video_sdram_rdata = sdram_rdata;

  // Ownership: held from the grant until the transaction's final ack.
  always_comb begin
    owner_d   = owner_q;
    ack_cnt_d = ack_cnt_q;
    unique case (owner_q)
      OWN_IDLE: begin
        ack_cnt_d = '0;
        if (grant_video) begin
          owner_d = OWN_VIDEO;
        end else if (grant_cpu) begin
          owner_d = OWN_CPU;
        end
      end
      OWN_CPU: begin
        if (sdram_ack) begin
          owner_d = OWN_IDLE;
        end
      end
      OWN_VIDEO: begin
        if (sdram_ack) begin
          if (ack_cnt_q == LAST_ACK) begin
            owner_d   = OWN_IDLE;
            ack_cnt_d = '0;
          end else begin
            ack_cnt_d = ack_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        owner_d   = OWN_IDLE;
        ack_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q   <= OWN_IDLE;
      ack_cnt_q <= '0;
    end else begin
      owner_q   <= owner_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: vector table, corner sequences, random vs model.
module tb_sdram_port_arbiter;

  localparam int BL = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sdram_rd, sdram_wr, sdram_burst;
  logic [23:0] sdram_addr_x16;
  logic [15:0] sdram_wdata;
  logic [1:0]  sdram_wmask;
  logic [15:0] sdram_rdata;
  logic        sdram_ack, sdram_rdy;
  logic        cpu_sdram_rd, cpu_sdram_wr;
  logic [23:0] cpu_sdram_addr_x16;
  logic [15:0] cpu_sdram_wdata;
  logic [1:0]  cpu_sdram_wmask;
  logic [15:0] cpu_sdram_rdata;
  logic        cpu_sdram_ack, cpu_sdram_rdy;
  logic        video_sdram_rd;
  logic [23:0] video_sdram_addr_x16;
  logic [15:0] video_sdram_rdata;
  logic        video_sdram_ack, video_sdram_rdy;

  sdram_port_arbiter #(.BURST_LEN(BL), .ADDR_W(24)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_addr_x16(sdram_addr_x16),
    .sdram_wdata(sdram_wdata), .sdram_wmask(sdram_wmask), .sdram_burst(sdram_burst),
    .sdram_rdata(sdram_rdata), .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
    .cpu_sdram_rd(cpu_sdram_rd), .cpu_sdram_wr(cpu_sdram_wr),
    .cpu_sdram_addr_x16(cpu_sdram_addr_x16), .cpu_sdram_wdata(cpu_sdram_wdata),
    .cpu_sdram_wmask(cpu_sdram_wmask), .cpu_sdram_rdata(cpu_sdram_rdata),
    .cpu_sdram_ack(cpu_sdram_ack), .cpu_sdram_rdy(cpu_sdram_rdy),
    .video_sdram_rd(video_sdram_rd), .video_sdram_addr_x16(video_sdram_addr_x16),
    .video_sdram_rdata(video_sdram_rdata), .video_sdram_ack(video_sdram_ack),
    .video_sdram_rdy(video_sdram_rdy)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Expected outputs for the current cycle: {rd,wr,burst}, {cpu,video} rdy/ack.
  logic [2:0]  e_str;
  logic [23:0] e_addr;
  logic [15:0] e_wdata;
  logic [1:0]  e_wmask, e_rdy, e_ack;

  // Reference model: who owns the controller and how many acks remain.
  int m_owner;      // 0 idle, 1 cpu, 2 video
  int m_left;
  bit m_last_video;
  bit m_gv, m_gc;

  typedef struct {
    logic        rdy, ack;
    logic [15:0] rdata;
    logic        c_rd, c_wr;
    logic [23:0] c_addr;
    logic [15:0] c_wdata;
    logic [1:0]  c_wmask;
    logic        v_rd;
    logic [23:0] v_addr;
    logic [2:0]  x_str;
    logic [23:0] x_addr;
    logic [15:0] x_wdata;
    logic [1:0]  x_wmask, x_rdy, x_ack;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rdy, ack, input logic [15:0] rdata,
    input logic c_rd, c_wr, input logic [23:0] c_addr, input logic [15:0] c_wdata,
    input logic [1:0] c_wmask, input logic v_rd, input logic [23:0] v_addr,
    input logic [2:0] x_str, input logic [23:0] x_addr, input logic [15:0] x_wdata,
    input logic [1:0] x_wmask, x_rdy, x_ack);
    vec_t v;
    v.rdy = rdy; v.ack = ack; v.rdata = rdata;
    v.c_rd = c_rd; v.c_wr = c_wr; v.c_addr = c_addr; v.c_wdata = c_wdata; v.c_wmask = c_wmask;
    v.v_rd = v_rd; v.v_addr = v_addr;
    v.x_str = x_str; v.x_addr = x_addr; v.x_wdata = x_wdata; v.x_wmask = x_wmask;
    v.x_rdy = x_rdy; v.x_ack = x_ack;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic check_exp(input string tag);
    chk({tag, " strobes"}, {29'd0, sdram_rd, sdram_wr, sdram_burst}, {29'd0, e_str});
    chk({tag, " addr"},    {8'd0, sdram_addr_x16}, {8'd0, e_addr});
    chk({tag, " wdata"},   {16'd0, sdram_wdata}, {16'd0, e_wdata});
    chk({tag, " wmask"},   {30'd0, sdram_wmask}, {30'd0, e_wmask});
    chk({tag, " rdy"},     {30'd0, cpu_sdram_rdy, video_sdram_rdy}, {30'd0, e_rdy});
    chk({tag, " ack"},     {30'd0, cpu_sdram_ack, video_sdram_ack}, {30'd0, e_ack});
    chk({tag, " rdata"},   {cpu_sdram_rdata, video_sdram_rdata}, {sdram_rdata, sdram_rdata});
  endtask

  task automatic model_reset();
    m_owner = 0; m_left = 0; m_last_video = 1'b0;
  endtask

  task automatic model_eval();
    bit gp, cr;
    gp   = (m_owner == 0) && sdram_rdy && !rst_i;
    cr   = cpu_sdram_rd || cpu_sdram_wr;
    m_gv = gp && video_sdram_rd;
    m_gc = gp && cr && !video_sdram_rd;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    if (gp && cr && video_sdram_rd) begin
      m_gv = !m_last_video;
      m_gc = m_last_video;
    end
`endif
    e_str   = {m_gv || (m_gc && !cpu_sdram_wr), m_gc && cpu_sdram_wr, m_gv};
    e_addr  = m_gv ? video_sdram_addr_x16 : cpu_sdram_addr_x16;
    e_wdata = m_gv ? 16'h0000 : cpu_sdram_wdata;
    e_wmask = m_gv ? 2'b11 : cpu_sdram_wmask;
    e_rdy   = {m_gc, m_gv};
    e_ack   = {sdram_ack && m_owner == 1, sdram_ack && m_owner == 2};
  endtask

  task automatic model_update();
    if (rst_i) begin
      model_reset();
    end else if (m_gv) begin
      m_owner = 2; m_left = BL; m_last_video = 1'b1;
    end else if (m_gc) begin
      m_owner = 1; m_left = 1; m_last_video = 1'b0;
    end else if (m_owner != 0 && sdram_ack) begin
      m_left--;
      if (m_left == 0) m_owner = 0;
    end
  endtask

  task automatic cycle_begin();
    @(negedge clk_i);
    model_eval();
  endtask

  task automatic cycle_end();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    sdram_rdy = 1'b0; sdram_ack = 1'b0; sdram_rdata = '0;
    cpu_sdram_rd = 1'b0; cpu_sdram_wr = 1'b0; cpu_sdram_addr_x16 = '0;
    cpu_sdram_wdata = '0; cpu_sdram_wmask = '0;
    video_sdram_rd = 1'b0; video_sdram_addr_x16 = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) begin cycle_begin(); cycle_end(); end
    rst_i = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_pat;
    bit         got[$];
    int         due;
    bit         cpu_pend, vid_pend, c_acc, v_acc;
    int         kind;

    // Reset state: requests present and controller ready, yet nothing granted.
    rst_i = 1'b1;
    idle_inputs();
    model_reset();
    cpu_sdram_rd = 1'b1; video_sdram_rd = 1'b1; sdram_rdy = 1'b1; sdram_ack = 1'b1;
    cycle_begin();
    chk("reset strobes", {29'd0, sdram_rd, sdram_wr, sdram_burst}, 32'd0);
    chk("reset rdy", {30'd0, cpu_sdram_rdy, video_sdram_rdy}, 32'd0);
    chk("reset ack", {30'd0, cpu_sdram_ack, video_sdram_ack}, 32'd0);
    cycle_end();
    do_reset();

    // rdy ack rdata | crd cwr caddr cwdata cwmask | vrd vaddr || str addr wdata wmask rdy ack
    vecs.push_back(mk(1,0,16'h0000, 0,0,24'h000000,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000000,16'h0000,2'b00,2'b00,2'b00));
    vecs.push_back(mk(1,0,16'h0000, 1,0,24'h000123,16'h0000,2'b00, 0,24'h0, 3'b100,24'h000123,16'h0000,2'b00,2'b10,2'b00));
    vecs.push_back(mk(1,0,16'h0000, 0,0,24'h000000,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000000,16'h0000,2'b00,2'b00,2'b00));
    vecs.push_back(mk(1,1,16'hBEEF, 0,0,24'h000000,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000000,16'h0000,2'b00,2'b00,2'b10));
    vecs.push_back(mk(1,0,16'h0000, 0,0,24'h000000,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000000,16'h0000,2'b00,2'b00,2'b00));
    vecs.push_back(mk(1,0,16'h0000, 0,1,24'h000456,16'h55AA,2'b01, 0,24'h0, 3'b010,24'h000456,16'h55AA,2'b01,2'b10,2'b00));
    vecs.push_back(mk(1,1,16'h0000, 0,0,24'h000000,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000000,16'h0000,2'b00,2'b00,2'b10));
    vecs.push_back(mk(1,0,16'h0000, 1,0,24'h000789,16'h0000,2'b00, 1,24'h100000, 3'b101,24'h100000,16'h0000,2'b11,2'b01,2'b00));
    vecs.push_back(mk(1,1,16'h1111, 1,0,24'h000789,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000789,16'h0000,2'b00,2'b00,2'b01));
    vecs.push_back(mk(1,1,16'h2222, 1,0,24'h000789,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000789,16'h0000,2'b00,2'b00,2'b01));
    vecs.push_back(mk(1,0,16'h0000, 1,0,24'h000789,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000789,16'h0000,2'b00,2'b00,2'b00));
    vecs.push_back(mk(1,1,16'h3333, 1,0,24'h000789,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000789,16'h0000,2'b00,2'b00,2'b01));
    vecs.push_back(mk(1,1,16'h4444, 1,0,24'h000789,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000789,16'h0000,2'b00,2'b00,2'b01));
    vecs.push_back(mk(1,0,16'h0000, 1,0,24'h000789,16'h0000,2'b00, 0,24'h0, 3'b100,24'h000789,16'h0000,2'b00,2'b10,2'b00));
    vecs.push_back(mk(0,1,16'h1234, 0,0,24'h000000,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000000,16'h0000,2'b00,2'b00,2'b10));
    vecs.push_back(mk(0,0,16'h0000, 0,1,24'h00ABCD,16'h1111,2'b10, 0,24'h0, 3'b000,24'h00ABCD,16'h1111,2'b10,2'b00,2'b00));
    vecs.push_back(mk(0,0,16'h0000, 0,1,24'h00ABCD,16'h1111,2'b10, 0,24'h0, 3'b000,24'h00ABCD,16'h1111,2'b10,2'b00,2'b00));
    vecs.push_back(mk(1,0,16'h0000, 0,1,24'h00ABCD,16'h1111,2'b10, 0,24'h0, 3'b010,24'h00ABCD,16'h1111,2'b10,2'b10,2'b00));
    vecs.push_back(mk(1,1,16'h0000, 0,0,24'h000000,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000000,16'h0000,2'b00,2'b00,2'b10));
    vecs.push_back(mk(1,1,16'h5A5A, 0,0,24'h000000,16'h0000,2'b00, 0,24'h0, 3'b000,24'h000000,16'h0000,2'b00,2'b00,2'b00));

    foreach (vecs[i]) begin
      sdram_rdy = vecs[i].rdy; sdram_ack = vecs[i].ack; sdram_rdata = vecs[i].rdata;
      cpu_sdram_rd = vecs[i].c_rd; cpu_sdram_wr = vecs[i].c_wr;
      cpu_sdram_addr_x16 = vecs[i].c_addr; cpu_sdram_wdata = vecs[i].c_wdata;
      cpu_sdram_wmask = vecs[i].c_wmask;
      video_sdram_rd = vecs[i].v_rd; video_sdram_addr_x16 = vecs[i].v_addr;
      cycle_begin();
      e_str = vecs[i].x_str; e_addr = vecs[i].x_addr; e_wdata = vecs[i].x_wdata;
      e_wmask = vecs[i].x_wmask; e_rdy = vecs[i].x_rdy; e_ack = vecs[i].x_ack;
      check_exp($sformatf("vec%0d", i));
      cycle_end();
    end

    // Reset in the middle of a video burst, after two acks.
    do_reset();
    video_sdram_rd = 1'b1; video_sdram_addr_x16 = 24'h0ABC00; sdram_rdy = 1'b1;
    cycle_begin();
    chk("rstburst grant", {29'd0, sdram_rd, sdram_burst, video_sdram_rdy}, 32'd7);
    cycle_end();
    video_sdram_rd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sdram_ack = 1'b1;
      cycle_begin();
      chk("rstburst ack", {31'd0, video_sdram_ack}, 32'd1);
      cycle_end();
    end
    rst_i = 1'b1; model_reset(); video_sdram_rd = 1'b1;
    #1;
    chk("rstburst strobes", {27'd0, sdram_rd, sdram_wr, sdram_burst, cpu_sdram_rdy, video_sdram_rdy}, 32'd0);
    chk("rstburst ackdrop", {30'd0, cpu_sdram_ack, video_sdram_ack}, 32'd0);
    cycle_begin(); cycle_end();
    rst_i = 1'b0; video_sdram_rd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sdram_ack = 1'b1;
      cycle_begin();
      chk("postrst ackdrop", {30'd0, cpu_sdram_ack, video_sdram_ack}, 32'd0);
      cycle_end();
    end

    // Both masters requesting continuously: record the grant order.
    do_reset();
    cpu_sdram_rd = 1'b1; cpu_sdram_addr_x16 = 24'h000042;
    video_sdram_rd = 1'b1; video_sdram_addr_x16 = 24'h200000; sdram_rdy = 1'b1;
    due = 0;
    for (int cyc = 0; cyc < 80 && got.size() < 4; cyc++) begin
      sdram_ack = (due > 0);
      cycle_begin();
      if (due > 0) due--;
      if (sdram_rd) begin
        got.push_back(sdram_burst);
        due = sdram_burst ? BL : 1;
      end
      cycle_end();
    end
    sdram_ack = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_pat = 4'b0101;
`else
    exp_pat = 4'b1111;
`endif
    chk("grant count", got.size(), 32'd4);
    foreach (got[i]) chk($sformatf("grant order %0d", i), {31'd0, got[i]}, {31'd0, exp_pat[i]});
    // Let the last transaction drain before the random phase.
    cpu_sdram_rd = 1'b0; video_sdram_rd = 1'b0;
    for (int i = 0; i < BL + 2; i++) begin
      sdram_ack = 1'b1; cycle_begin(); cycle_end();
    end

    // Randomized traffic against the reference model.
    do_reset();
    cpu_pend = 1'b0; vid_pend = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!cpu_pend) begin
        cpu_sdram_addr_x16 = 24'($urandom); cpu_sdram_wdata = 16'($urandom);
        cpu_sdram_wmask = 2'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          cpu_pend = 1'b1;
          kind = $urandom_range(0, 9);
          cpu_sdram_wr = (kind < 4);
          cpu_sdram_rd = (kind >= 4) || (kind == 0);
        end
      end
      if (!vid_pend) begin
        video_sdram_addr_x16 = 24'($urandom);
        if ($urandom_range(0, 4) == 0) begin
          vid_pend = 1'b1; video_sdram_rd = 1'b1;
        end
      end
      sdram_rdy = ($urandom_range(0, 3) != 0);
      sdram_ack = ($urandom_range(0, 2) == 0);
      sdram_rdata = 16'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst_i = 1'b1; model_reset();
      end else begin
        rst_i = 1'b0;
      end
      cycle_begin();
      check_exp($sformatf("rnd%0d", n));
      c_acc = m_gc; v_acc = m_gv;
      cycle_end();
      if (c_acc) begin cpu_pend = 1'b0; cpu_sdram_rd = 1'b0; cpu_sdram_wr = 1'b0; end
      if (v_acc) begin vid_pend = 1'b0; video_sdram_rd = 1'b0; end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
